// File: rtl/window_gen_5x5_if.sv
//------------------------------------------------------------------------------
// Module  : window_gen_5x5_if
// Brief   : Pixel-in / 5x5-window-out bundle for the window generator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface window_gen_5x5_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] S1,  S2,  S3,  S4,  S5;
  logic [7:0] S6,  S7,  S8,  S9,  S10;
  logic [7:0] S11, S12, S13, S14, S15;
  logic [7:0] S16, S17, S18, S19, S20;
  logic [7:0] S21, S22, S23, S24, S25;
  logic       done_o;
  logic       frame_done_o;

  modport master (
    output data_i, valid_i,
    input  S1,  S2,  S3,  S4,  S5,  S6,  S7,  S8,  S9,  S10,
    input  S11, S12, S13, S14, S15, S16, S17, S18, S19, S20,
    input  S21, S22, S23, S24, S25,
    input  done_o, frame_done_o
  );

  modport slave (
    input  data_i, valid_i,
    output S1,  S2,  S3,  S4,  S5,  S6,  S7,  S8,  S9,  S10,
    output S11, S12, S13, S14, S15, S16, S17, S18, S19, S20,
    output S21, S22, S23, S24, S25,
    output done_o, frame_done_o
  );
endinterface

`default_nettype wire

// File: rtl/window_gen_5x5.sv
//------------------------------------------------------------------------------
// Module  : window_gen_5x5
// Brief   : Raster-stream 5x5 sliding window generator using four line buffers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module window_gen_5x5 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  window_gen_5x5_if.slave  bus
);

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = $clog2(IMG_H);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
  localparam logic [c_col_w-1:0] c_col_first_win = c_col_w'(4);
  localparam logic [c_row_w-1:0] c_row_first_win = c_row_w'(4);

  logic [c_col_w-1:0]  r_col;
  logic [c_row_w-1:0]  r_row;
  logic                r_done;
  logic                r_frame_done;
  logic [4:0][4:0][7:0] r_win;

  logic                w_accept;
  logic                w_col_end;
  logic                w_row_end;
  logic [3:0][7:0]     w_lb_rd;
  logic [4:0][7:0]     w_col_in;

  assign w_accept  = bus.valid_i;
  assign w_col_end = (r_col == c_col_last);
  assign w_row_end = (r_row == c_row_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Buffer k holds row r-(k+1); each accepted pixel pushes the column down the chain.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lb
      logic [7:0] r_mem [IMG_W];

      assign w_lb_rd[k] = r_mem[r_col];

      if (k == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (w_accept) r_mem[r_col] <= bus.data_i;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (w_accept) r_mem[r_col] <= w_lb_rd[k-1];
        end
      end
    end
  endgenerate

  // Window row 0 is the oldest line (buffer 3), row 4 the incoming pixel.
  assign w_col_in[4] = bus.data_i;
  generate
    for (genvar r = 0; r < 4; r++) begin : g_col
      assign w_col_in[r] = w_lb_rd[3-r];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 5; r++) begin
        r_win[r] <= {w_col_in[r], r_win[r][4:1]};
      end
    end
  end

  // Border gating also hides stale line-buffer data after reset or a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_done       <= w_accept && (r_row >= c_row_first_win) && (r_col >= c_col_first_win);
      r_frame_done <= w_accept && w_col_end && w_row_end;
    end
  end

  assign bus.done_o       = r_done;
  assign bus.frame_done_o = r_frame_done;

  assign bus.S1  = r_win[0][0];
  assign bus.S2  = r_win[0][1];
  assign bus.S3  = r_win[0][2];
  assign bus.S4  = r_win[0][3];
  assign bus.S5  = r_win[0][4];
  assign bus.S6  = r_win[1][0];
  assign bus.S7  = r_win[1][1];
  assign bus.S8  = r_win[1][2];
  assign bus.S9  = r_win[1][3];
  assign bus.S10 = r_win[1][4];
  assign bus.S11 = r_win[2][0];
  assign bus.S12 = r_win[2][1];
  assign bus.S13 = r_win[2][2];
  assign bus.S14 = r_win[2][3];
  assign bus.S15 = r_win[2][4];
  assign bus.S16 = r_win[3][0];
  assign bus.S17 = r_win[3][1];
  assign bus.S18 = r_win[3][2];
  assign bus.S19 = r_win[3][3];
  assign bus.S20 = r_win[3][4];
  assign bus.S21 = r_win[4][0];
  assign bus.S22 = r_win[4][1];
  assign bus.S23 = r_win[4][2];
  assign bus.S24 = r_win[4][3];
  assign bus.S25 = r_win[4][4];

endmodule

`default_nettype wire

// File: tb/tb_window_gen_5x5.sv
//------------------------------------------------------------------------------
// Module  : tb_window_gen_5x5
// Brief   : Scoreboard bench for window_gen_5x5 on an 8x6 image.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [199:0] win;
    logic         fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  window_gen_5x5_if bus ();

  window_gen_5x5 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_win = 0;
  int n_fd  = 0;
  exp_t         exp_q [$];
  logic [199:0] got_q [$];
  logic [7:0]   pix [H][W];

  logic [199:0] got_now;
  assign got_now = {bus.S1,  bus.S2,  bus.S3,  bus.S4,  bus.S5,
                    bus.S6,  bus.S7,  bus.S8,  bus.S9,  bus.S10,
                    bus.S11, bus.S12, bus.S13, bus.S14, bus.S15,
                    bus.S16, bus.S17, bus.S18, bus.S19, bus.S20,
                    bus.S21, bus.S22, bus.S23, bus.S24, bus.S25};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] s_at(input logic [199:0] w, input int idx);
    return w[199-8*(idx-1) -: 8];
  endfunction

  // Monitor: checks every output cycle against the scoreboard and gap rules.
  logic         prev_valid = 1'b1;
  logic [199:0] prev_s     = '0;
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (got_now !== '0 || bus.done_o !== 1'b0 || bus.frame_done_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: got win=%h done=%b fd=%b expected all 0",
                 got_now, bus.done_o, bus.frame_done_o);
      end
      prev_valid = 1'b1;
    end else begin
      if (!prev_valid) begin
        total++;
        if (bus.done_o !== 1'b0 || got_now !== prev_s) begin
          bad++;
          $display("FAIL gap_hold: got done=%b win=%h expected done=0 win=%h",
                   bus.done_o, got_now, prev_s);
        end
      end
      if (bus.done_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got window %h expected no window", got_now);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (got_now !== e.win || bus.frame_done_o !== e.fd) begin
            bad++;
            $display("FAIL window: got %h fd=%b expected %h fd=%b",
                     got_now, bus.frame_done_o, e.win, e.fd);
          end
        end
        got_q.push_back(got_now);
        n_win++;
      end else if (bus.frame_done_o !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL fd_without_done: got frame_done=%b expected 0", bus.frame_done_o);
      end
      if (bus.frame_done_o === 1'b1) n_fd++;
      prev_valid = bus.valid_i;
    end
    prev_s = got_now;
  end

  task automatic idle();
    @(posedge clk);
    #2;
    bus.valid_i = 1'b0;
  endtask

  task automatic drive_pix(input logic [7:0] v);
    @(posedge clk);
    #2;
    bus.valid_i = 1'b1;
    bus.data_i  = v;
  endtask

  // gap_mode: 0 none, 1 one idle after every pixel, 2 random 0..2 idles
  task automatic send_frame(input int off, input int gap_mode, input bit rnd, input int last_idx);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c <= last_idx) begin
          logic [7:0] v;
          v = rnd ? 8'($urandom_range(0, 255)) : 8'(r * W + c + off);
          pix[r][c] = v;
          if (r >= 4 && c >= 4) begin
            exp_t e;
            for (int i = 0; i < 25; i++) e.win[199-8*i -: 8] = pix[r-4+i/5][c-4+i%5];
            e.fd = (r == H-1) && (c == W-1);
            exp_q.push_back(e);
          end
          drive_pix(v);
          if (gap_mode == 1) idle();
          else if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle();
        end
      end
    end
  endtask

  task automatic drain();
    repeat (4) idle();
  endtask

  initial begin
    int w0, f0;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Continuous frame
    got_q.delete();
    w0 = n_win; f0 = n_fd;
    send_frame(0, 0, 1'b0, W*H-1);
    drain();
    chk("t1_count", n_win - w0, 8);
    chk("t1_frame_done", n_fd - f0, 1);
    if (got_q.size() == 8) begin
      chk("t1_first_S1",  s_at(got_q[0], 1), 0);
      chk("t1_first_S5",  s_at(got_q[0], 5), 4);
      chk("t1_first_S13", s_at(got_q[0], 13), 18);
      chk("t1_first_S21", s_at(got_q[0], 21), 32);
      chk("t1_first_S25", s_at(got_q[0], 25), 36);
      chk("t1_last_S25",  s_at(got_q[7], 25), 47);
    end

    // Valid toggled every cycle
    w0 = n_win; f0 = n_fd;
    send_frame(0, 1, 1'b0, W*H-1);
    drain();
    chk("t2_count", n_win - w0, 8);
    chk("t2_frame_done", n_fd - f0, 1);

    // Back-to-back frames, second offset by 100
    got_q.delete();
    w0 = n_win; f0 = n_fd;
    send_frame(0, 0, 1'b0, W*H-1);
    send_frame(100, 0, 1'b0, W*H-1);
    drain();
    chk("t3_count", n_win - w0, 16);
    chk("t3_frame_done", n_fd - f0, 2);
    if (got_q.size() == 16) begin
      chk("t3_f2_first_S1",  s_at(got_q[8], 1), 100);
      chk("t3_f2_first_S25", s_at(got_q[8], 25), 136);
      for (int k = 8; k < 16; k++) begin
        int mn;
        mn = 255;
        for (int i = 1; i <= 25; i++) if (s_at(got_q[k], i) < mn) mn = s_at(got_q[k], i);
        chk("t3_f2_min_ge_100", (mn >= 100) ? 1 : 0, 1);
      end
    end

    // Reset mid-frame after pixel 30; valid held high during reset must be ignored
    w0 = n_win;
    send_frame(50, 0, 1'b0, 30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hAA;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    bus.valid_i = 1'b0;
    chk("t4_no_window_partial", n_win - w0, 0);
    got_q.delete();
    w0 = n_win; f0 = n_fd;
    send_frame(0, 0, 1'b0, W*H-1);
    drain();
    chk("t4_count", n_win - w0, 8);
    chk("t4_frame_done", n_fd - f0, 1);
    if (got_q.size() > 0) begin
      chk("t4_first_S1",  s_at(got_q[0], 1), 0);
      chk("t4_first_S25", s_at(got_q[0], 25), 36);
    end

    // Random data with random gaps, three frames
    w0 = n_win; f0 = n_fd;
    repeat (3) send_frame(0, 2, 1'b1, W*H-1);
    drain();
    chk("t5_count", n_win - w0, 24);
    chk("t5_frame_done", n_fd - f0, 3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
